// File: rtl/lcd_fill_engine.sv
`default_nettype none
// ============================================================================
// lcd_fill_engine : rectangle-fill command/pixel sequencer feeding the LCD SPI
//                   serializer. Define LCD_FILL_STREAM_EN to take pixels from a
//                   valid/ready stream instead of the constant request colour.
// Revision        : 1.0
// ============================================================================
module lcd_fill_engine #(
   parameter logic [7:0] CMD_CASET = 8'h2A,
   parameter logic [7:0] CMD_RASET = 8'h2B,
   parameter logic [7:0] CMD_RAMWR = 8'h2C
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_x0,
   input  logic [7:0]  req_x1,
   input  logic [7:0]  req_y0,
   input  logic [7:0]  req_y1,
   input  logic [15:0] req_color,
`ifdef LCD_FILL_STREAM_EN
   input  logic        pix_valid,
   input  logic [15:0] pix_data,
   output logic        pix_ready,
`endif
   input  logic        d8_full,
   output logic        d8_wr,
   output logic [7:0]  d8_wdata,
   input  logic        d16_full,
   input  logic        d16_empty,
   output logic        d16_wr,
   output logic [15:0] d16_wdata,
   input  logic        ser_idle,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DRAIN = 3'd1,
      S_CMD   = 3'd2,
      S_PIX   = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_req_ready;
   logic [7:0]  r_x0, r_x1, r_y0, r_y1;
   logic [15:0] r_color;
   logic        r_err;
   logic [3:0]  r_idx;
   logic        r_cmd_wait;
   logic [7:0]  r_cx, r_cy;
   logic [7:0]  r_d8_byte;

   logic        w_hs;
   logic        w_bad;
   logic        w_d8_wr;
   logic        w_d16_wr;
   logic [15:0] w_pix_word;
   logic        w_last_col;
   logic        w_last;

   function automatic logic [7:0] f_cmd_byte(input logic [3:0] idx);
      case (idx)
         4'd0:    return CMD_CASET;
         4'd2:    return r_x0;
         4'd4:    return r_x1;
         4'd5:    return CMD_RASET;
         4'd7:    return r_y0;
         4'd9:    return r_y1;
         4'd10:   return CMD_RAMWR;
         default: return 8'h00;
      endcase
   endfunction

   assign w_hs       = req_valid & r_req_ready;
   assign w_bad      = (req_x1 < req_x0) | (req_y1 < req_y0);
   assign w_d8_wr    = (r_state == S_CMD) & ~r_cmd_wait & ~d8_full;
   assign w_last_col = (r_cx == r_x1);
   assign w_last     = w_last_col & (r_cy == r_y1);

`ifdef LCD_FILL_STREAM_EN
   assign pix_ready  = (r_state == S_PIX) & ~d16_full;
   assign w_d16_wr   = pix_ready & pix_valid;
   assign w_pix_word = pix_data;
`else
   assign w_d16_wr   = (r_state == S_PIX) & ~d16_full;
   assign w_pix_word = r_color;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_hs) w_next = w_bad ? S_FIN : S_DRAIN;
         S_DRAIN: if (d16_empty & ser_idle) w_next = S_CMD;
         // the last command byte must leave the SPI before pixels start
         S_CMD:   if (r_cmd_wait & ~d8_full & ser_idle) w_next = S_PIX;
         S_PIX:   if (w_d16_wr & w_last) w_next = S_FIN;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_req_ready <= 1'b0;
         r_x0        <= '0;
         r_x1        <= '0;
         r_y0        <= '0;
         r_y1        <= '0;
         r_color     <= '0;
         r_err       <= 1'b0;
         r_idx       <= '0;
         r_cmd_wait  <= 1'b0;
         r_cx        <= '0;
         r_cy        <= '0;
         r_d8_byte   <= '0;
      end else begin
         r_state     <= w_next;
         r_req_ready <= (w_next == S_IDLE);
         if (w_hs) begin
            r_x0    <= req_x0;
            r_x1    <= req_x1;
            r_y0    <= req_y0;
            r_y1    <= req_y1;
            r_color <= req_color;
            r_err   <= w_bad;
            r_cx    <= req_x0;
            r_cy    <= req_y0;
         end
         if ((r_state == S_DRAIN) && (w_next == S_CMD)) begin
            r_idx      <= '0;
            r_cmd_wait <= 1'b0;
            r_d8_byte  <= CMD_CASET;
         end else if (w_d8_wr) begin
            if (r_idx == 4'd10) begin
               r_cmd_wait <= 1'b1;
            end else begin
               r_idx     <= r_idx + 4'd1;
               r_d8_byte <= f_cmd_byte(r_idx + 4'd1);
            end
         end
         if (w_d16_wr) begin
            if (w_last_col) begin
               r_cx <= r_x0;
               if (!w_last) r_cy <= r_cy + 8'd1;
            end else begin
               r_cx <= r_cx + 8'd1;
            end
         end
      end
   end

   assign req_ready = r_req_ready;
   assign d8_wr     = w_d8_wr;
   assign d8_wdata  = w_d8_wr ? r_d8_byte : 8'h00;
   assign d16_wr    = w_d16_wr;
   assign d16_wdata = w_d16_wr ? w_pix_word : 16'h0000;
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_FIN);
   assign err       = (r_state == S_FIN) & r_err;

endmodule
`default_nettype wire

// File: tb/tb_lcd_fill_engine.sv
`default_nettype none
// Testbench for lcd_fill_engine: table-driven fills with queue scoreboard,
// plus drain-wait and mid-fill reset sequences.
module tb_lcd_fill_engine;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_x0, req_x1, req_y0, req_y1;
   logic [15:0] req_color;
   logic        d8_full, d8_wr;
   logic [7:0]  d8_wdata;
   logic        d16_full, d16_empty, d16_wr;
   logic [15:0] d16_wdata;
   logic        ser_idle, busy, done, err;
`ifdef LCD_FILL_STREAM_EN
   logic        pix_valid, pix_ready;
   logic [15:0] pix_data;
   assign pix_valid = 1'b1;
   assign pix_data  = req_color;
`endif

   lcd_fill_engine dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1),
      .req_color(req_color),
`ifdef LCD_FILL_STREAM_EN
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
`endif
      .d8_full(d8_full), .d8_wr(d8_wr), .d8_wdata(d8_wdata),
      .d16_full(d16_full), .d16_empty(d16_empty), .d16_wr(d16_wr),
      .d16_wdata(d16_wdata), .ser_idle(ser_idle),
      .busy(busy), .done(done), .err(err)
   );

   typedef struct {
      logic [7:0]  x0, x1, y0, y1;
      logic [15:0] color;
      int          bp;
      bit          exp_err;
      int          exp_n;
   } vec_t;

   vec_t        vecs [0:6];
   logic [7:0]  q8[$];
   logic [15:0] q16[$];
   int total = 0, bad = 0;
   int cyc = 0;
   int bp_mode = 0;
   int n8, n16, ndone, first_d8, last_d8, first16, last16, done_cyc, hs_cyc;
   bit got_err, prev_done;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // backpressure generator
   initial begin
      d8_full  = 1'b0;
      d16_full = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (bp_mode)
            1: begin d8_full = 1'b0; d16_full = ~d16_full; end
            2: begin
               d8_full  = ($urandom_range(0, 3) == 0);
               d16_full = ($urandom_range(0, 2) == 0);
            end
            default: begin d8_full = 1'b0; d16_full = 1'b0; end
         endcase
      end
   end

   // output monitor and scoreboard
   always @(negedge clk) begin
      logic [15:0] e;
      chk("d8_wr_while_full", d8_wr & d8_full, 0);
      chk("d16_wr_while_full", d16_wr & d16_full, 0);
      chk("err_without_done", err & ~done, 0);
      if (prev_done) chk("ready_after_done", req_ready, 1);
      prev_done = done;
      if (d8_wr) begin
         if (n8 == 0) first_d8 = cyc;
         last_d8 = cyc;
         n8++;
         if (q8.size() == 0) chk("d8_unexpected", 1, 0);
         else begin
            e = {8'h00, q8.pop_front()};
            chk("d8_data", d8_wdata, e);
         end
      end else begin
         chk("d8_idle_data", d8_wdata, 0);
      end
      if (d16_wr) begin
         if (n16 == 0) first16 = cyc;
         last16 = cyc;
         n16++;
         if (q16.size() == 0) chk("d16_unexpected", 1, 0);
         else begin
            e = q16.pop_front();
            chk("d16_data", d16_wdata, e);
         end
      end else begin
         chk("d16_idle_data", d16_wdata, 0);
      end
      if (done) begin
         ndone++;
         done_cyc = cyc;
         got_err  = err;
      end
   end

   task automatic start_req(input logic [7:0] x0, x1, y0, y1,
                            input logic [15:0] color, input bit bad_req);
      int k;
      if (!bad_req) begin
         q8.push_back(8'h2A); q8.push_back(8'h00); q8.push_back(x0);
         q8.push_back(8'h00); q8.push_back(x1);
         q8.push_back(8'h2B); q8.push_back(8'h00); q8.push_back(y0);
         q8.push_back(8'h00); q8.push_back(y1);
         q8.push_back(8'h2C);
         for (int y = y0; y <= int'(y1); y++)
            for (int x = x0; x <= int'(x1); x++)
               q16.push_back(color);
      end
      n8 = 0; n16 = 0; ndone = 0; got_err = 1'b0;
      k = 0;
      while (!req_ready && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      chk("req_ready_wait", req_ready, 1);
      req_x0 = x0; req_x1 = x1; req_y0 = y0; req_y1 = y1; req_color = color;
      req_valid = 1'b1;
      hs_cyc = cyc;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic finish_req(input bit exp_err, input int exp_n, input bit strict);
      int k;
      k = 0;
      while (ndone == 0 && k < 70000) begin
         @(posedge clk); #1;
         k++;
      end
      chk("done_seen", ndone > 0, 1);
      @(posedge clk); #1;
      chk("done_count", ndone, 1);
      chk("err_flag", got_err, exp_err);
      chk("d8_count", n8, exp_err ? 0 : 11);
      chk("d16_count", n16, exp_n);
      chk("q8_left", q8.size(), 0);
      chk("q16_left", q16.size(), 0);
      if (strict) begin
         if (exp_err) begin
            chk("reject_latency", done_cyc - hs_cyc, 1);
         end else begin
            chk("first_d8_latency", first_d8 - hs_cyc, 2);
            chk("cmd_burst", last_d8 - first_d8, 10);
            chk("pix_burst", last16 - first16 + 1, exp_n);
            chk("done_after_last", done_cyc - last16, 1);
         end
      end
   endtask

   initial begin
      int k, saved16, saved8, rel_cyc;
      vecs[0] = '{x0:8'd5,   x1:8'd5,   y0:8'd7,   y1:8'd7,   color:16'hF800, bp:0, exp_err:1'b0, exp_n:1};
      vecs[1] = '{x0:8'd0,   x1:8'd3,   y0:8'd0,   y1:8'd1,   color:16'h1234, bp:1, exp_err:1'b0, exp_n:8};
      vecs[2] = '{x0:8'd10,  x1:8'd9,   y0:8'd0,   y1:8'd0,   color:16'h0000, bp:0, exp_err:1'b1, exp_n:0};
      vecs[3] = '{x0:8'd0,   x1:8'd0,   y0:8'd3,   y1:8'd2,   color:16'hFFFF, bp:0, exp_err:1'b1, exp_n:0};
      vecs[4] = '{x0:8'd250, x1:8'd255, y0:8'd254, y1:8'd255, color:16'hABCD, bp:2, exp_err:1'b0, exp_n:12};
      vecs[5] = '{x0:8'd2,   x1:8'd4,   y0:8'd3,   y1:8'd5,   color:16'h5555, bp:2, exp_err:1'b0, exp_n:9};
      vecs[6] = '{x0:8'd0,   x1:8'd239, y0:8'd0,   y1:8'd239, color:16'h07E0, bp:0, exp_err:1'b0, exp_n:57600};

      rst_n = 1'b0; req_valid = 1'b0;
      req_x0 = '0; req_x1 = '0; req_y0 = '0; req_y1 = '0; req_color = '0;
      d16_empty = 1'b1; ser_idle = 1'b1;
      n8 = 0; n16 = 0; ndone = 0; prev_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_d8_wr", d8_wr, 0);
      chk("rst_d16_wr", d16_wr, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_release", req_ready, 1);

      for (int i = 0; i < 7; i++) begin
         bp_mode = vecs[i].bp;
         start_req(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1,
                   vecs[i].color, vecs[i].exp_err);
         finish_req(vecs[i].exp_err, vecs[i].exp_n, vecs[i].bp == 0);
      end
      bp_mode = 0;

      // request while pixel FIFO still holds data, then serializer busy
      d16_empty = 1'b0;
      start_req(8'd0, 8'd1, 8'd0, 8'd0, 16'h0F0F, 1'b0);
      repeat (8) @(posedge clk);
      #1;
      chk("drain_no_d8_not_empty", n8, 0);
      chk("drain_busy", busy, 1);
      d16_empty = 1'b1; ser_idle = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("drain_no_d8_ser_busy", n8, 0);
      ser_idle = 1'b1;
      rel_cyc = cyc;
      finish_req(1'b0, 2, 1'b0);
      chk("drain_release_latency", first_d8 - rel_cyc, 1);

      // reset in the middle of a 400-pixel fill
      start_req(8'd0, 8'd19, 8'd0, 8'd19, 16'h1F1F, 1'b0);
      k = 0;
      while (n16 < 100 && k < 1000) begin
         @(posedge clk); #1;
         k++;
      end
      chk("reached_pixel_100", n16 >= 100, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_d16_wr", d16_wr, 0);
      chk("midrst_d8_wr", d8_wr, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_req_ready", req_ready, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      q8.delete(); q16.delete();
      saved16 = n16; saved8 = n8;
      @(posedge clk); #1;
      chk("postrst_ready", req_ready, 1);
      chk("postrst_busy", busy, 0);
      repeat (20) @(posedge clk);
      #1;
      chk("postrst_no_d16", n16, saved16);
      chk("postrst_no_d8", n8, saved8);
      chk("postrst_idle", busy, 0);

      start_req(8'd1, 8'd2, 8'd3, 8'd3, 16'hC0DE, 1'b0);
      finish_req(1'b0, 2, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
